// File: rtl/chacha_xor_stream.sv
// chacha_xor_stream: XORs a plaintext byte stream with keystream bytes
// prefetched from a ChaCha block core. Every message starts on a fresh
// 64-byte block. When a message ends part-way through a block, the rest of
// that block is read and thrown away before the next message may start.
module chacha_xor_stream #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       blk_ready,
  output logic       rd_blk,
  input  logic [7:0] ks_data,
  input  logic       pt_valid,
  output logic       pt_ready,
  input  logic       pt_last,
  input  logic [7:0] pt_data,
  output logic       ct_valid,
  input  logic       ct_ready,
  output logic       ct_last,
  output logic [7:0] ct_data,
  output logic       blk_done,
  output logic [5:0] blk_pos
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [0:0]    state_reg;
  logic [1:0]    start_reg;
  logic          inflight_reg;
  logic [5:0]    blk_pos_reg;
  logic          blk_done_reg;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          ct_valid_reg;
  logic          ct_last_reg;
  logic [7:0]    ct_data_reg;

  logic       in_run;
  logic       fifo_empty;
  logic       room;
  logic       pt_fire;
  logic       ct_fire;
  logic       at_boundary;
  logic       go_drain;
  logic       go_run;
  logic       push;
  logic [7:0] head_byte;

  // Room counts the byte already requested but not yet written, so a read
  // issued now can never overflow the FIFO. In DRAIN the room check is
  // dropped because nothing is stored; reading stops once the block wraps.
  assign in_run      = (state_reg == ST_RUN);
  assign fifo_empty  = (count_reg == '0);
  assign room        = (count_reg + {{AW{1'b0}}, inflight_reg}) < CNT_MAX;
  assign rd_blk      = start_reg[1] & blk_ready & (in_run ? room : ~blk_done_reg);
  assign pt_ready    = in_run & ~fifo_empty & (~ct_valid_reg | ct_ready);
  assign pt_fire     = pt_valid & pt_ready;
  assign ct_fire     = ct_valid_reg & ct_ready;
  assign head_byte   = fifo_mem[rd_ptr_reg];

  // A last byte that empties the FIFO exactly on a block boundary leaves
  // nothing to discard, so DRAIN is skipped in that case.
  assign at_boundary = (blk_pos_reg == 6'd0) & ~inflight_reg & (count_reg == CNT_ONE);
  assign go_drain    = pt_fire & pt_last & ~at_boundary;
  assign go_run      = ~in_run & blk_done_reg;
  assign push        = inflight_reg & in_run & ~go_drain;

  assign ct_valid    = ct_valid_reg;
  assign ct_last     = ct_last_reg;
  assign ct_data     = ct_data_reg;
  assign blk_done    = blk_done_reg;
  assign blk_pos     = blk_pos_reg;

  // Read bookkeeping: start-up delay, in-flight flag, block position and wrap pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_reg    <= 2'b00;
      inflight_reg <= 1'b0;
      blk_pos_reg  <= 6'd0;
      blk_done_reg <= 1'b0;
    end else begin
      start_reg    <= {start_reg[0], 1'b1};
      inflight_reg <= rd_blk;
      blk_done_reg <= rd_blk & (blk_pos_reg == 6'd63);
      if (rd_blk) begin
        blk_pos_reg <= blk_pos_reg + 6'd1;
      end
    end
  end

  // RUN/DRAIN control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_RUN;
    end else if (go_drain) begin
      state_reg <= ST_DRAIN;
    end else if (go_run) begin
      state_reg <= ST_RUN;
    end
  end

  // FIFO pointers and occupancy; entering DRAIN flushes everything held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (go_drain) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pt_fire) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      unique case ({push, pt_fire})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // FIFO storage: keystream byte captured the cycle after its read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= ks_data;
    end
  end

  // Ciphertext output register; a new load may replace a byte leaving this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ct_valid_reg <= 1'b0;
      ct_last_reg  <= 1'b0;
      ct_data_reg  <= 8'h00;
    end else if (pt_fire) begin
      ct_valid_reg <= 1'b1;
      ct_last_reg  <= pt_last;
      ct_data_reg  <= pt_data ^ head_byte;
    end else if (ct_fire) begin
      ct_valid_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_chacha_xor_stream.sv
// Testbench for chacha_xor_stream: a queue-based reference model of the
// keystream prefetch and message draining rules, compared every cycle,
// plus literal expectations for the directed scenarios.
module tb_chacha_xor_stream;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       blk_ready = 1'b0;
  logic       rd_blk;
  logic [7:0] ks_data = 8'h00;
  logic       pt_valid = 1'b0;
  logic       pt_ready;
  logic       pt_last = 1'b0;
  logic [7:0] pt_data = 8'h00;
  logic       ct_valid;
  logic       ct_ready = 1'b0;
  logic       ct_last;
  logic [7:0] ct_data;
  logic       blk_done;
  logic [5:0] blk_pos;

  chacha_xor_stream #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .blk_ready(blk_ready), .rd_blk(rd_blk),
    .ks_data(ks_data), .pt_valid(pt_valid), .pt_ready(pt_ready),
    .pt_last(pt_last), .pt_data(pt_data), .ct_valid(ct_valid),
    .ct_ready(ct_ready), .ct_last(ct_last), .ct_data(ct_data),
    .blk_done(blk_done), .blk_pos(blk_pos)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cycle = 0;

  // Reference model: FIFO as a queue of global keystream indices.
  bit         m_run = 1'b1;
  int         q[$];
  bit         m_pend = 1'b0;
  int         m_pend_idx = 0;
  int         m_reads = 0;
  bit         m_done = 1'b0;
  bit         m_ctv = 1'b0;
  logic [7:0] m_ctd = 8'h00;
  bit         m_ctl = 1'b0;
  int         m_start = 0;
  bit         obs_run = 1'b1;

  // Keystream core and plaintext source driven by the bench.
  int  core_reads = 0;
  bit  core_fire = 1'b0;
  int  core_idx = 0;
  int  lim = 0;
  int  br_pct = 100;
  int  pv_pct = 100;
  int  cr_pct = 100;
  int  msg_left = 0;
  int  pt_fix = -1;
  bit  pv_hold = 1'b0;
  bit  pt_have = 1'b0;
  logic [7:0] ct_log[$];
  int  ct_cyc[$];
  int  done_cnt = 0;
  int  first_rd = -1;
  int  rel_cycle = 0;
  logic o_rd, o_ptr, o_ctv, o_done;
  logic [5:0] o_pos;

  // Byte p of block b is p + 17*b (mod 256): block 0 is 0x00..0x3F.
  function automatic logic [7:0] ks_byte(input int k);
    int v;
    v = (k % 64) + 17 * (k / 64);
    return v[7:0];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic cyc();
    bit exp_rd, exp_ptr, hs_p, hs_c, to_drain, to_run;
    int idx;
    @(negedge clk);
    cycle++;
    ks_data   = core_fire ? ks_byte(core_idx) : 8'($urandom);
    blk_ready = (core_reads < lim) && ($urandom_range(99) < br_pct);
    if (msg_left > 0 && !pt_have) begin
      pt_data = (pt_fix >= 0) ? 8'(pt_fix) : 8'($urandom);
      pt_have = 1'b1;
    end
    pt_last  = (msg_left == 1);
    pt_valid = (msg_left > 0) && (pv_hold || ($urandom_range(99) < pv_pct));
    pv_hold  = pt_valid;
    ct_ready = ($urandom_range(99) < cr_pct);
    #1;
    o_rd = rd_blk; o_ptr = pt_ready; o_ctv = ct_valid; o_done = blk_done; o_pos = blk_pos;
    obs_run = m_run;

    exp_rd  = blk_ready && (m_start >= 2) &&
              (m_run ? ((q.size() + int'(m_pend)) < DEPTH) : !m_done);
    exp_ptr = m_run && (q.size() > 0) && (!m_ctv || ct_ready);
    chk("rd_blk",   rd_blk,   exp_rd);
    chk("pt_ready", pt_ready, exp_ptr);
    chk("ct_valid", ct_valid, m_ctv);
    chk("ct_data",  ct_data,  m_ctd);
    chk("ct_last",  ct_last,  m_ctl);
    chk("blk_pos",  blk_pos,  m_reads % 64);
    chk("blk_done", blk_done, m_done);

    // Core and source react to what the DUT actually did.
    core_fire = rd_blk;
    if (rd_blk) begin
      core_idx = core_reads;
      core_reads++;
      if (first_rd < 0) first_rd = cycle - rel_cycle - 1;
    end
    if (ct_valid && ct_ready) begin
      ct_log.push_back(ct_data);
      ct_cyc.push_back(cycle);
    end
    if (blk_done) done_cnt++;
    if (pt_valid && pt_ready) begin
      msg_left--;
      pv_hold = 1'b0;
      pt_have = 1'b0;
    end

    // Advance the model across the coming rising edge.
    hs_p = pt_valid && exp_ptr;
    hs_c = m_ctv && ct_ready;
    to_drain = 1'b0;
    to_run = 1'b0;
    if (hs_p) begin
      idx   = q.pop_front();
      m_ctd = pt_data ^ ks_byte(idx);
      m_ctl = pt_last;
      m_ctv = 1'b1;
    end else if (hs_c) begin
      m_ctv = 1'b0;
    end
    if (m_run && hs_p && pt_last && !((m_reads % 64 == 0) && !m_pend && q.size() == 0))
      to_drain = 1'b1;
    if (!m_run && m_done) to_run = 1'b1;
    if (m_pend && m_run && !to_drain) q.push_back(m_pend_idx);
    if (to_drain) q.delete();
    m_done = exp_rd && (m_reads % 64 == 63);
    m_pend = exp_rd;
    if (exp_rd) begin
      m_pend_idx = m_reads;
      m_reads++;
    end
    if (to_drain) m_run = 1'b0;
    else if (to_run) m_run = 1'b1;
    m_start++;
  endtask

  // Assert reset between edges and check that outputs clear at once.
  task automatic assert_reset(input string tag);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, "_rd_blk"},   rd_blk,   0);
    chk({tag, "_pt_ready"}, pt_ready, 0);
    chk({tag, "_ct_valid"}, ct_valid, 0);
    chk({tag, "_ct_data"},  ct_data,  0);
    chk({tag, "_ct_last"},  ct_last,  0);
    chk({tag, "_blk_done"}, blk_done, 0);
    chk({tag, "_blk_pos"},  blk_pos,  0);
    m_run = 1'b1; q.delete(); m_pend = 1'b0; m_done = 1'b0;
    m_ctv = 1'b0; m_ctd = 8'h00; m_ctl = 1'b0; m_start = 0;
    core_reads = ((core_reads + 63) / 64) * 64;
    m_reads = core_reads;
    core_fire = 1'b0;
    msg_left = 0; pv_hold = 1'b0; pt_have = 1'b0; pt_valid = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    rel_cycle = cycle;
    first_rd = -1;
  endtask

  task automatic run_reads(input int target, input int budget);
    int k = 0;
    while (core_reads < target && k < budget) begin cyc(); k++; end
    chk("reads_reached", core_reads, target);
  endtask

  task automatic run_log(input int n, input int budget);
    int k = 0;
    while (ct_log.size() < n && k < budget) begin cyc(); k++; end
    chk("ct_count", ct_log.size(), n);
  endtask

  task automatic run_msg(input int budget);
    int k = 0;
    while (msg_left > 0 && k < budget) begin cyc(); k++; end
    chk("msg_done", msg_left, 0);
  endtask

  initial begin
    int base;
    int done_base;
    int ks_base;

    assert_reset("rst0");
    release_reset();

    // Keystream 0x00.., eight 0xFF bytes at full rate after prefetch.
    lim = 64;
    repeat (8) cyc();
    pt_fix = 8'hFF;
    msg_left = 8;
    run_log(8, 40);
    for (int i = 0; i < 8; i++) chk("fullrate_ct", ct_log[i], 255 - i);
    chk("fullrate_span", ct_cyc[7] - ct_cyc[0], 7);
    run_reads(64, 200);
    repeat (3) cyc();
    chk("first_drain_done", done_cnt, 1);

    // Output stalled with a full FIFO, then a 5-byte message drains its block.
    lim = 128;
    repeat (8) cyc();
    pt_fix = -1;
    cr_pct = 0;
    msg_left = 5;
    base = ct_log.size();
    repeat (12) cyc();
    chk("stall_pt_ready", o_ptr, 0);
    chk("stall_rd_blk", o_rd, 0);
    chk("stall_ct_valid", o_ctv, 1);
    chk("stall_no_output", ct_log.size(), base);
    done_base = done_cnt;
    cr_pct = 100;
    run_log(base + 5, 40);
    run_reads(128, 300);
    repeat (3) cyc();
    chk("drain_done_once", done_cnt - done_base, 1);

    // Next message starts on block 2; a full 64-byte message needs no drain.
    lim = 192;
    pt_fix = 0;
    msg_left = 64;
    base = ct_log.size();
    run_log(base + 64, 400);
    chk("next_block_byte0", ct_log[base], 8'h22);
    repeat (4) cyc();
    lim = 256;
    msg_left = 1;
    run_log(base + 65, 40);
    chk("no_drain_byte0", ct_log[base + 64], 8'h33);
    run_reads(256, 400);
    repeat (3) cyc();

    // Core stalls at block position 20 for seven cycles.
    lim = 276;
    pt_fix = -1;
    msg_left = 40;
    run_reads(276, 200);
    repeat (7) begin
      cyc();
      chk("stall_blk_pos", o_pos, 20);
      chk("stall_no_read", o_rd, 0);
    end
    lim = 320;
    run_msg(300);
    run_reads(320, 300);
    repeat (3) cyc();

    // Randomised traffic.
    lim = 1 << 30;
    br_pct = 75; pv_pct = 80; cr_pct = 70;
    repeat (2500) begin
      if (msg_left == 0 && $urandom_range(3) == 0) msg_left = $urandom_range(1, 90);
      cyc();
    end
    run_msg(2000);

    // Reset while draining with a read in flight.
    br_pct = 100; pv_pct = 100; cr_pct = 100;
    msg_left = 2;
    begin
      int k = 0;
      bit seen = 1'b0;
      while (!seen && k < 300) begin
        cyc();
        seen = !obs_run && o_rd;
        k++;
      end
      chk("drain_read_seen", seen, 1);
    end
    assert_reset("rst_drain");
    release_reset();
    ks_base = core_reads;
    pt_fix = 0;
    msg_left = 3;
    base = ct_log.size();
    run_log(base + 3, 60);
    chk("post_reset_byte0", ct_log[base], ks_byte(ks_base));
    chk("post_reset_rd_delay", first_rd >= 2, 1);
    repeat (80) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
